// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and helpers for the ALU / mul-div block.
package alu_pkg;

  // Base op codes, op[3:0] with op[4]=0
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  // M op codes, op[2:0] with op[4]=1
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed division overflow: dividend is most-negative and divisor is -1
  function automatic logic sdiv_ovf(input logic a_msb, input logic a_rest_zero,
                                    input logic b_all_ones);
    return a_msb & a_rest_zero & b_all_ones;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide sequencer with sign fix-up
// and divide special cases (divide-by-zero, signed overflow).
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter bit          DIV_EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            early_c,
  output logic [XLEN-1:0] early_res_c,
  output logic            done_c,
  output logic [XLEN-1:0] res_c
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] acc_hi, acc_lo, m_op;
  logic [CW-1:0]   count;
  logic [2:0]      fn_q;
  logic            qneg_q, rneg_q, spec_q;
  logic [XLEN-1:0] spec_res_q;

  logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, dz_in, ovf_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, spec_res_in;

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_n, lo_n, q_fix, r_fix;
  logic [2*XLEN-1:0] prod;

  // Decode the offered operands: signedness, magnitudes and special cases
  always_comb begin
    is_div_in   = fn[2];
    a_sgn_in    = is_div_in ? ~fn[0] : ((fn == M_MULH) || (fn == M_MULHSU));
    b_sgn_in    = is_div_in ? ~fn[0] : (fn == M_MULH);
    a_neg_in    = a_sgn_in & a[XLEN-1];
    b_neg_in    = b_sgn_in & b[XLEN-1];
    a_mag_in    = a_neg_in ? (XLEN'(0) - a) : a;
    b_mag_in    = b_neg_in ? (XLEN'(0) - b) : b;
    dz_in       = is_div_in & (b == '0);
    ovf_in      = is_div_in & ~fn[0] &
                  sdiv_ovf(a[XLEN-1], a[XLEN-2:0] == '0, &b);
    spec_res_in = dz_in ? (fn[1] ? a : '1) : (fn[1] ? '0 : a);
    early_c     = DIV_EARLY_OUT & (dz_in | ovf_in);
    early_res_c = spec_res_in;
  end

  // One iteration step plus final sign correction / result select
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_op} : '0);
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, m_op};
    div_ge   = ~div_diff[XLEN];
    if (fn_q[2]) begin
      hi_n = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      lo_n = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod  = qneg_q ? ((2*XLEN)'(0) - {hi_n, lo_n}) : {hi_n, lo_n};
    q_fix = qneg_q ? (XLEN'(0) - lo_n) : lo_n;
    r_fix = rneg_q ? (XLEN'(0) - hi_n) : hi_n;
    if (spec_q)
      res_c = spec_res_q;
    else if (fn_q[2])
      res_c = fn_q[1] ? r_fix : q_fix;
    else
      res_c = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    done_c = (count == CW'(1));
  end

  // Sequencer state: load on start, step while count is non-zero
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      acc_hi     <= '0;
      acc_lo     <= '0;
      m_op       <= '0;
      count      <= '0;
      fn_q       <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else if (start) begin
      acc_hi     <= '0;
      acc_lo     <= is_div_in ? a_mag_in : b_mag_in;
      m_op       <= is_div_in ? b_mag_in : a_mag_in;
      count      <= CW'(XLEN);
      fn_q       <= fn;
      qneg_q     <= a_neg_in ^ b_neg_in;
      rneg_q     <= a_neg_in;
      spec_q     <= dz_in | ovf_in;
      spec_res_q <= spec_res_in;
    end else if (count != '0) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage integer ALU with iterative M-extension unit behind valid/ready.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter bit          DIV_EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero,
  output logic            s_less,
  output logic            u_less
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_t          state, state_nxt;
  logic [XLEN-1:0] y_nxt, base_res, seq_res_c, early_res_c;
  logic            accept, seq_start, seq_done_c, early_c;
  logic [SHW-1:0]  shamt;

  assign in_ready = (state == ST_IDLE);

  muldiv_iter #(
    .XLEN         (XLEN),
    .DIV_EARLY_OUT(DIV_EARLY_OUT)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start      (seq_start),
    .kill       (kill),
    .fn         (op[2:0]),
    .a          (a),
    .b          (b),
    .early_c    (early_c),
    .early_res_c(early_res_c),
    .done_c     (seq_done_c),
    .res_c      (seq_res_c)
  );

  // Single-cycle base op datapath
  always_comb begin
    base_res = '0;
    shamt    = b[SHW-1:0];
    case (op[3:0])
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_ADD:  base_res = a + b;
      OP_SLL:  base_res = a << shamt;
      OP_SLT:  base_res = XLEN'($signed(a) < $signed(b));
      OP_SLTU: base_res = XLEN'(a < b);
      OP_SUB:  base_res = a - b;
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = XLEN'($signed(a) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // Next-state and result select; kill overrides everything
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    accept    = 1'b0;
    seq_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (!op[4]) begin
            y_nxt     = base_res;
            state_nxt = ST_DONE;
          end else if (early_c) begin
            y_nxt     = early_res_c;
            state_nxt = ST_DONE;
          end else begin
            seq_start = 1'b1;
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (seq_done_c) begin
          y_nxt     = seq_res_c;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) begin
      state_nxt = ST_IDLE;
      y_nxt     = y;
      accept    = 1'b0;
      seq_start = 1'b0;
    end
  end

  // State, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      y         <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      s_less    <= 1'b0;
      u_less    <= 1'b0;
    end else begin
      state     <= state_nxt;
      y         <= y_nxt;
      zero      <= (y_nxt == '0);
      out_valid <= (state_nxt == ST_DONE);
      if (accept) begin
        s_less <= ($signed(a) < $signed(b));
        u_less <= (a < b);
      end
    end
  end

endmodule
